id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports valid_D input 1 and ready_D output 1: upstream decode handshake.
REQ-005 SHALL have port stall_D  input  1  load-use stall from hazard unit; blocks acceptance.
REQ-006 SHALL have port flush  input  1  branch/jump redirect; kills the held instruction.
REQ-007 SHALL have inputs type_D 5, rs1_D 5, rs2_D 5, rd_D 5, load_D 1, pc_D XLEN, imm_D XLEN, rdata1_D XLEN, rdata2_D XLEN: decoded instruction and register-file read data.
REQ-008 SHALL have inputs forward_rs1 XLEN, forward_rs2 XLEN, valid_forward_rs1 1, valid_forward_rs2 1: registered forwarding, aligned to the cycle the instruction sits in this stage.
REQ-009 SHALL have output valid_E 1 and input ready_E 1: downstream execute handshake.
REQ-010 SHALL have outputs type_E 5, rd_E 5, load_E 1, pc_E XLEN, imm_E XLEN, op1_E XLEN, op2_E XLEN.

Function
REQ-011 SHALL implement FSM states EMPTY (valid_E=0), FULL (first cycle holding instruction), HOLD (held >=1 cycle with ready_E=0).
REQ-012 SHALL drive ready_D = ~stall_D & ~flush & (state==EMPTY | ready_E).
REQ-013 SHALL load instruction fields, rdata1_D, rdata2_D into stage registers on valid_D & ready_D; next state FULL.
REQ-014 SHALL, when no transfer in and (state==EMPTY or ready_E=1), go EMPTY next cycle (bubble on stall_D or valid_D=0).
REQ-015 SHALL, in FULL, drive op1_E = valid_forward_rs1 ? forward_rs1 : registered rdata1; op2_E likewise with rs2.
REQ-016 SHALL, in FULL with ready_E=0, capture current op1_E/op2_E into hold registers and move to HOLD.
REQ-017 SHALL, in HOLD, drive op1_E/op2_E from hold registers, ignoring forward inputs.
REQ-018 SHALL, in HOLD with ready_E=1, go FULL on new transfer in, else EMPTY.
REQ-019 SHALL force op1_E=0 when registered rs1 is 0, op2_E=0 when registered rs2 is 0, regardless of forward inputs.
REQ-020 SHALL give flush priority over all: next state EMPTY, valid_E=0 next cycle, no instruction accepted in flush cycle.
REQ-021 SHALL present all outputs combinationally from stage/hold registers; latency D->E exactly 1 cycle.
REQ-022 SHALL keep type_E, rd_E, load_E, pc_E, imm_E stable while valid_E=1 and ready_E=0.

Reset
REQ-023 SHALL, on rst_n=0, immediately enter EMPTY and clear valid_E.
REQ-024 SHALL reset all stage/hold registers to 0, so every output reads 0 while in reset.
REQ-025 SHALL drop any in-flight instruction on reset mid-operation; first acceptance possible the cycle after rst_n rises.

Structure
REQ-026 SHALL take XLEN default, 5-bit instruction-type encoding, and FSM state enum from shared package pipe_pkg.
REQ-027 SHALL instantiate sub-module operand_hold twice (rs1, rs2): forward mux, x0 zeroing, HOLD capture register.

Verification
REQ-028 SHALL cover back-to-back: two instrs, ready_E=1, stall_D=0 -> valid_E=1 on consecutive cycles, pc_E 0x100 then 0x104.
REQ-029 SHALL cover forward: rdata1_D=0x11, valid_forward_rs1=1, forward_rs1=0xAA in FULL -> op1_E=0xAA.
REQ-030 SHALL cover hold: FULL, ready_E=0 two cycles, forward_rs2=0x55 then 0x99 -> op2_E=0x55 both cycles, ready_D=0.
REQ-031 SHALL cover load-use: stall_D=1 one cycle with valid_D=1 -> ready_D=0, one valid_E=0 bubble, instr accepted next cycle.
REQ-032 SHALL cover flush+x0: flush during HOLD -> valid_E=0 next cycle; rs1_D=0, forward_rs1=0xFFFFFFFF valid -> op1_E=0.
REQ-033 SHALL cover async reset: rst_n=0 mid-HOLD between edges -> valid_E=0 immediately, all outputs 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types: datapath width default, instruction-type encoding and
// the ID/EX stage occupancy states.
package pipe_pkg;

  localparam int unsigned XlenDefault = 32;
  localparam int unsigned TypeW       = 5;
  localparam int unsigned RegW        = 5;

  typedef enum logic [TypeW-1:0] {
    TypeNone   = 5'd0,
    TypeAlu    = 5'd1,
    TypeAluImm = 5'd2,
    TypeLoad   = 5'd3,
    TypeStore  = 5'd4,
    TypeBranch = 5'd5,
    TypeJal    = 5'd6,
    TypeJalr   = 5'd7,
    TypeLui    = 5'd8,
    TypeAuipc  = 5'd9
  } instr_type_e;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StHold  = 2'd2
  } stage_state_e;

  function automatic logic is_x0(input logic [RegW-1:0] rs);
    return rs == '0;
  endfunction

endpackage

// File: rtl/operand_hold.sv
// One source operand of the ID/EX stage: forward mux, x0 zeroing and a capture
// register that freezes the operand while execute back-pressures.
module operand_hold
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RegW-1:0] rs_i,
  input  logic [XLEN-1:0] rdata_i,
  input  logic [XLEN-1:0] fwd_i,
  input  logic            fwd_valid_i,
  input  logic            hold_sel_i,
  input  logic            capture_i,
  output logic [XLEN-1:0] op_o
);

  logic [XLEN-1:0] hold_q, hold_d;

  // x0 wins over everything, including a stale hold value.
  always_comb begin
    if (is_x0(rs_i)) begin
      op_o = '0;
    end else if (hold_sel_i) begin
      op_o = hold_q;
    end else if (fwd_valid_i) begin
      op_o = fwd_i;
    end else begin
      op_o = rdata_i;
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (capture_i) begin
      hold_d = op_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, load-use stall, flush and
// operand forwarding that is frozen once the instruction is back-pressured.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_D,
  output logic             ready_D,
  input  logic             stall_D,
  input  logic             flush,
  input  logic [TypeW-1:0] type_D,
  input  logic [RegW-1:0]  rs1_D,
  input  logic [RegW-1:0]  rs2_D,
  input  logic [RegW-1:0]  rd_D,
  input  logic             load_D,
  input  logic [XLEN-1:0]  pc_D,
  input  logic [XLEN-1:0]  imm_D,
  input  logic [XLEN-1:0]  rdata1_D,
  input  logic [XLEN-1:0]  rdata2_D,
  input  logic [XLEN-1:0]  forward_rs1,
  input  logic [XLEN-1:0]  forward_rs2,
  input  logic             valid_forward_rs1,
  input  logic             valid_forward_rs2,
  output logic             valid_E,
  input  logic             ready_E,
  output logic [TypeW-1:0] type_E,
  output logic [RegW-1:0]  rd_E,
  output logic             load_E,
  output logic [XLEN-1:0]  pc_E,
  output logic [XLEN-1:0]  imm_E,
  output logic [XLEN-1:0]  op1_E,
  output logic [XLEN-1:0]  op2_E
);

  stage_state_e    state_q, state_d;
  logic [TypeW-1:0] type_q, type_d;
  logic [RegW-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic             load_q, load_d;
  logic [XLEN-1:0]  pc_q, pc_d, imm_q, imm_d;
  logic [XLEN-1:0]  rdata1_q, rdata1_d, rdata2_q, rdata2_d;

  logic accept;
  logic capture;
  logic hold_sel;

  assign ready_D  = ~stall_D & ~flush & ((state_q == StEmpty) | ready_E);
  assign accept   = valid_D & ready_D;
  assign capture  = (state_q == StFull) & ~ready_E;
  assign hold_sel = (state_q == StHold);

  always_comb begin
    if (flush) begin
      state_d = StEmpty;
    end else if (accept) begin
      state_d = StFull;
    end else if ((state_q == StEmpty) || ready_E) begin
      state_d = StEmpty;
    end else begin
      state_d = StHold;
    end
  end

  always_comb begin
    type_d   = type_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    load_d   = load_q;
    pc_d     = pc_q;
    imm_d    = imm_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    if (accept) begin
      type_d   = type_D;
      rs1_d    = rs1_D;
      rs2_d    = rs2_D;
      rd_d     = rd_D;
      load_d   = load_D;
      pc_d     = pc_D;
      imm_d    = imm_D;
      rdata1_d = rdata1_D;
      rdata2_d = rdata2_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      type_q   <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      load_q   <= 1'b0;
      pc_q     <= '0;
      imm_q    <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      load_q   <= load_d;
      pc_q     <= pc_d;
      imm_q    <= imm_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
    end
  end

  operand_hold #(
    .XLEN(XLEN)
  ) u_op1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs_i       (rs1_q),
    .rdata_i    (rdata1_q),
    .fwd_i      (forward_rs1),
    .fwd_valid_i(valid_forward_rs1),
    .hold_sel_i (hold_sel),
    .capture_i  (capture),
    .op_o       (op1_E)
  );

  operand_hold #(
    .XLEN(XLEN)
  ) u_op2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs_i       (rs2_q),
    .rdata_i    (rdata2_q),
    .fwd_i      (forward_rs2),
    .fwd_valid_i(valid_forward_rs2),
    .hold_sel_i (hold_sel),
    .capture_i  (capture),
    .op_o       (op2_E)
  );

  assign valid_E = (state_q != StEmpty);
  assign type_E  = type_q;
  assign rd_E    = rd_q;
  assign load_E  = load_q;
  assign pc_E    = pc_q;
  assign imm_E   = imm_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic checked against
// a transaction-level model of the stage occupant.
module tb_id_ex_stage;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid_D, ready_D, stall_D, flush;
  logic [4:0]      type_D, rs1_D, rs2_D, rd_D;
  logic            load_D;
  logic [XLEN-1:0] pc_D, imm_D, rdata1_D, rdata2_D;
  logic [XLEN-1:0] forward_rs1, forward_rs2;
  logic            valid_forward_rs1, valid_forward_rs2;
  logic            valid_E, ready_E;
  logic [4:0]      type_E, rd_E;
  logic            load_E;
  logic [XLEN-1:0] pc_E, imm_E, op1_E, op2_E;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the instruction occupying the stage.
  bit              m_valid, m_held;
  logic [4:0]      m_type, m_rs1, m_rs2, m_rd;
  logic            m_load;
  logic [XLEN-1:0] m_pc, m_imm, m_rd1, m_rd2, m_h1, m_h2;

  always #5 clk = ~clk;

  id_ex_stage #(
    .XLEN(XLEN)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_D          (valid_D),
    .ready_D          (ready_D),
    .stall_D          (stall_D),
    .flush            (flush),
    .type_D           (type_D),
    .rs1_D            (rs1_D),
    .rs2_D            (rs2_D),
    .rd_D             (rd_D),
    .load_D           (load_D),
    .pc_D             (pc_D),
    .imm_D            (imm_D),
    .rdata1_D         (rdata1_D),
    .rdata2_D         (rdata2_D),
    .forward_rs1      (forward_rs1),
    .forward_rs2      (forward_rs2),
    .valid_forward_rs1(valid_forward_rs1),
    .valid_forward_rs2(valid_forward_rs2),
    .valid_E          (valid_E),
    .ready_E          (ready_E),
    .type_E           (type_E),
    .rd_E             (rd_E),
    .load_E           (load_E),
    .pc_E             (pc_E),
    .imm_E            (imm_E),
    .op1_E            (op1_E),
    .op2_E            (op2_E)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_op(input logic [4:0] rs, input bit held,
                                             input logic [XLEN-1:0] h, input logic vf,
                                             input logic [XLEN-1:0] f,
                                             input logic [XLEN-1:0] rd);
    if (rs == 5'd0) return '0;
    if (held) return h;
    return vf ? f : rd;
  endfunction

  task automatic clear_inputs();
    valid_D = 0; stall_D = 0; flush = 0; ready_E = 1;
    type_D = 0; rs1_D = 0; rs2_D = 0; rd_D = 0; load_D = 0;
    pc_D = 0; imm_D = 0; rdata1_D = 0; rdata2_D = 0;
    forward_rs1 = 0; forward_rs2 = 0; valid_forward_rs1 = 0; valid_forward_rs2 = 0;
  endtask

  task automatic model_reset();
    m_valid = 0; m_held = 0;
    m_type = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_load = 0;
    m_pc = 0; m_imm = 0; m_rd1 = 0; m_rd2 = 0; m_h1 = 0; m_h2 = 0;
  endtask

  task automatic set_instr(input logic [XLEN-1:0] pc, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [XLEN-1:0] rd1,
                           input logic [XLEN-1:0] rd2);
    valid_D = 1; pc_D = pc; rs1_D = rs1; rs2_D = rs2; rdata1_D = rd1; rdata2_D = rd2;
    type_D = 5'd1; rd_D = rs1 ^ 5'd7; load_D = 0; imm_D = pc + 32'h10;
  endtask

  task automatic rand_inputs();
    valid_D = ($urandom_range(0, 9) < 8);
    stall_D = ($urandom_range(0, 99) < 15);
    flush   = ($urandom_range(0, 99) < 8);
    ready_E = ($urandom_range(0, 9) < 6);
    type_D  = 5'($urandom);
    rs1_D   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    rs2_D   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    rd_D    = 5'($urandom);
    load_D  = 1'($urandom);
    pc_D    = $urandom; imm_D = $urandom;
    rdata1_D = $urandom; rdata2_D = $urandom;
    forward_rs1 = $urandom; forward_rs2 = $urandom;
    valid_forward_rs1 = 1'($urandom); valid_forward_rs2 = 1'($urandom);
  endtask

  // Called just after a rising edge with inputs applied; checks, advances the
  // model and returns one cycle later.
  task automatic step();
    logic            er;
    logic [XLEN-1:0] e1, e2;
    #2;
    er = !stall_D && !flush && (!m_valid || ready_E);
    e1 = exp_op(m_rs1, m_held, m_h1, valid_forward_rs1, forward_rs1, m_rd1);
    e2 = exp_op(m_rs2, m_held, m_h2, valid_forward_rs2, forward_rs2, m_rd2);
    check_eq("ready_D", ready_D, er);
    check_eq("valid_E", valid_E, m_valid);
    if (m_valid) begin
      check_eq("op1_E", op1_E, e1);
      check_eq("op2_E", op2_E, e2);
      check_eq("type_E", type_E, m_type);
      check_eq("rd_E", rd_E, m_rd);
      check_eq("load_E", load_E, m_load);
      check_eq("pc_E", pc_E, m_pc);
      check_eq("imm_E", imm_E, m_imm);
    end
    if (flush) begin
      m_valid = 0;
    end else if (valid_D && er) begin
      m_valid = 1; m_held = 0;
      m_type = type_D; m_rs1 = rs1_D; m_rs2 = rs2_D; m_rd = rd_D; m_load = load_D;
      m_pc = pc_D; m_imm = imm_D; m_rd1 = rdata1_D; m_rd2 = rdata2_D;
    end else if (!m_valid || ready_E) begin
      m_valid = 0;
    end else if (!m_held) begin
      m_h1 = e1; m_h2 = e2; m_held = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    valid_forward_rs1 = 1; forward_rs1 = 32'hFFFF_FFFF;
    valid_forward_rs2 = 1; forward_rs2 = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_valid_E", valid_E, 0);
    check_eq("rst_op1_E", op1_E, 0);
    check_eq("rst_op2_E", op2_E, 0);
    check_eq("rst_pc_E", pc_E, 0);
    @(posedge clk); #1;
    rst_n = 1;
    clear_inputs();

    // Back-to-back acceptance.
    set_instr(32'h100, 5'd1, 5'd2, 32'h1, 32'h2);
    step();
    check_eq("b2b_pc0", pc_E, 32'h100);
    set_instr(32'h104, 5'd3, 5'd4, 32'h3, 32'h4);
    step();
    check_eq("b2b_pc1", pc_E, 32'h104);
    check_eq("b2b_valid1", valid_E, 1);

    // Forwarding overrides register-file data.
    set_instr(32'h200, 5'd3, 5'd4, 32'h11, 32'h22);
    step();
    valid_D = 0; valid_forward_rs1 = 1; forward_rs1 = 32'hAA;
    #1 check_eq("fwd_op1", op1_E, 32'hAA);
    step();
    clear_inputs();

    // Back-pressure freezes the forwarded operand.
    set_instr(32'h300, 5'd6, 5'd5, 32'h33, 32'h44);
    step();
    valid_D = 0; ready_E = 0; valid_forward_rs2 = 1; forward_rs2 = 32'h55;
    #1 check_eq("hold_op2_c0", op2_E, 32'h55);
    check_eq("hold_rdy_c0", ready_D, 0);
    step();
    forward_rs2 = 32'h99;
    #1 check_eq("hold_op2_c1", op2_E, 32'h55);
    check_eq("hold_rdy_c1", ready_D, 0);
    step();
    clear_inputs();
    step();

    // Load-use stall inserts one bubble.
    set_instr(32'h400, 5'd7, 5'd8, 32'h7, 32'h8);
    stall_D = 1;
    #1 check_eq("lu_rdy", ready_D, 0);
    step();
    check_eq("lu_bubble", valid_E, 0);
    stall_D = 0;
    step();
    check_eq("lu_valid", valid_E, 1);
    check_eq("lu_pc", pc_E, 32'h400);
    clear_inputs();

    // x0 operand ignores forwarding; flush kills a held instruction.
    set_instr(32'h500, 5'd0, 5'd9, 32'h5, 32'h6);
    step();
    valid_D = 0; ready_E = 0; valid_forward_rs1 = 1; forward_rs1 = 32'hFFFF_FFFF;
    #1 check_eq("x0_op1", op1_E, 0);
    step();
    flush = 1; set_instr(32'h504, 5'd1, 5'd1, 32'h1, 32'h1);
    step();
    check_eq("flush_valid", valid_E, 0);
    clear_inputs();

    // Asynchronous reset while held.
    set_instr(32'h600, 5'd2, 5'd3, 32'h12, 32'h13);
    step();
    valid_D = 0; ready_E = 0; valid_forward_rs1 = 1; forward_rs1 = 32'h77;
    step();
    step();
    #2 rst_n = 0;
    #1;
    check_eq("arst_valid", valid_E, 0);
    check_eq("arst_pc", pc_E, 0);
    check_eq("arst_imm", imm_E, 0);
    check_eq("arst_type", type_E, 0);
    check_eq("arst_rd", rd_E, 0);
    check_eq("arst_load", load_E, 0);
    check_eq("arst_op1", op1_E, 0);
    check_eq("arst_op2", op2_E, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    clear_inputs();

    for (int i = 0; i < 500; i++) begin
      rand_inputs();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
